// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds.
// Read data is registered: a popped word appears on data_out one edge later with valid_out.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int U_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [U_WIDTH-1:0]    umbral_alto,
    input  logic [U_WIDTH-1:0]    umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [U_WIDTH-1:0]    count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [U_WIDTH-1:0] DEPTH_U = U_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [U_WIDTH-1:0]    count_reg;
    logic [U_WIDTH-1:0]    count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_reg;
    logic                  error_reg;
    logic                  error_next;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_U);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        count_next = count_reg;
        error_next = error_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + U_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - U_WIDTH'(1);
        end
        if ((push && !push_ok) || (pop && empty)) begin
            error_next = 1'b1;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            error_reg <= error_next;
            valid_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                data_out_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + ADDR_WIDTH'(1);
            end
        end
    end

    assign data_out     = data_out_reg;
    assign valid_out    = valid_reg;
    assign error        = error_reg;
    assign count        = count_reg;
    assign fifo_empty   = empty;
    assign fifo_full    = full;
    assign almost_full  = (count_reg >= umbral_alto);
    assign almost_empty = (count_reg <= umbral_bajo);

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: queue-based reference model, data scoreboard
// checked by a separate monitor, plus directed and randomized stimulus.
module tb_fifo_umbral;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int UW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [UW-1:0] umbral_alto;
    logic [UW-1:0] umbral_bajo;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [UW-1:0] count;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .U_WIDTH(UW)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int model_q[$];   // words held by the FIFO, oldest first
    int exp_q[$];     // words expected on data_out, oldest first
    bit model_err;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(string tag);
        int n;
        n = model_q.size();
        chk({tag, " count"},        int'(count),        n);
        chk({tag, " fifo_empty"},   int'(fifo_empty),   int'(n == 0));
        chk({tag, " fifo_full"},    int'(fifo_full),    int'(n == DEPTH));
        chk({tag, " almost_full"},  int'(almost_full),  int'(n >= int'(umbral_alto)));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(n <= int'(umbral_bajo)));
        chk({tag, " error"},        int'(error),        int'(model_err));
    endtask

    // One clock of stimulus: drive, let the edge happen, update the model, check state.
    task automatic step(bit p, int d, bit q, string tag);
        bit had;
        push    = p;
        data_in = DW'(d);
        pop     = q;
        @(posedge clk);
        had = (model_q.size() > 0);
        if (q && had) exp_q.push_back(model_q.pop_front());
        if (q && !had) model_err = 1'b1;
        if (p) begin
            if (model_q.size() < DEPTH) model_q.push_back(d & 'h3F);
            else model_err = 1'b1;
        end
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_state(tag);
        $display("%s push=%0b din=%02h pop=%0b count=%0d err=%0b", tag, p, d & 'h3F, q, count, error);
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        model_q.delete();
        exp_q.delete();
        model_err = 1'b0;
        #1;
        reset = 1'b0;
        check_state(tag);
        chk({tag, " valid_out"}, int'(valid_out), 0);
        $display("%s reset count=%0d", tag, count);
    endtask

    // Monitor: every presented word must match the oldest expectation,
    // and every expectation must have been presented by now.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected valid_out", 1, 0);
                end else begin
                    chk("data_out", int'(data_out), exp_q.pop_front());
                    $display("monitor data_out=%02h", data_out);
                end
            end
            if (exp_q.size() != 0) begin
                chk("missing valid_out", 0, exp_q.size());
                exp_q.delete();
            end
        end
    end

    initial begin
        reset       = 1'b1;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        model_err   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        for (int i = 1; i <= 8; i++) step(1, i, 0, "fill");
        for (int i = 0; i < 8; i++) step(0, 0, 1, "drain");
        step(0, 0, 0, "idle");

        for (int i = 0; i < 8; i++) step(1, 10 + i, 0, "fill2");
        step(1, 'h3F, 0, "overflow");
        for (int i = 0; i < 8; i++) step(0, 0, 1, "drain2");
        step(0, 0, 0, "idle");

        do_reset("reset2");
        step(0, 0, 1, "underflow");
        step(1, 5, 1, "pushpop_empty");
        step(0, 0, 1, "drain3");
        step(0, 0, 0, "idle");

        do_reset("reset3");
        for (int i = 0; i < 8; i++) step(1, 20 + i, 0, "fill3");
        for (int i = 0; i < 4; i++) step(1, 40 + i, 1, "pushpop_full");
        for (int i = 0; i < 8; i++) step(0, 0, 1, "drain4");
        step(0, 0, 0, "idle");

        do_reset("reset4");
        for (int i = 0; i < 3; i++) step(1, 50 + i, 0, "fill4");
        umbral_bajo = 4'd2;
        #1;
        check_state("bajo2");
        umbral_bajo = 4'd3;
        #1;
        check_state("bajo3");
        umbral_alto = 4'd0;
        #1;
        check_state("alto0");
        umbral_alto = 4'd9;
        umbral_bajo = 4'd8;
        for (int i = 0; i < 6; i++) step(1, 60 + i, 0, "thr_edge");
        umbral_alto = 4'd6;
        umbral_bajo = 4'd1;
        do_reset("reset_mid");
        step(0, 0, 0, "idle");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                umbral_alto = UW'($urandom_range(0, 15));
                umbral_bajo = UW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand_reset");
            end else begin
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), "rand");
            end
        end

        step(0, 0, 0, "idle");
        step(0, 0, 0, "idle");
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
